// File: rtl/hyperbus_rwds_lat_sampler_pkg.sv
// Shared types and helpers for the HyperBus RWDS latency sampler.
// Holds the control FSM encoding and the sample majority vote.
package hyperbus_rwds_lat_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    VOTE,
    WAIT_REL
  } state_e;

  localparam int unsigned MaxSamples = 7;

  // Only the low n bits of s take part in the vote.
  function automatic logic majority(logic [6:0] s, int n);
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) begin
      if ((i < n) && s[i]) ones++;
    end
    return (ones > (n / 2));
  endfunction

endpackage

// File: rtl/hyperbus_rwds_lat_sampler_dual_capture.sv
// RWDS capture: a negedge flop plus the posedge sample shift register.
// The polarity select picks which edge's view of RWDS gets shifted in.
module hyperbus_rwds_dual_capture #(
  parameter int NumSamples = 3
) (
  input  logic                  tx_clk_90,
  input  logic                  rst_ni,
  input  logic                  rwds,
  input  logic                  pol,
  input  logic                  shift_en,
  input  logic                  clear,
  output logic [NumSamples-1:0] samples
);

  logic neg_q;
  logic bit_sel;

  always_ff @(negedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= rwds;
    end
  end

  // pol=1 takes the value seen at the preceding negedge, pol=0 the live pad.
  assign bit_sel = pol ? neg_q : rwds;

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      samples <= '0;
    end else if (clear) begin
      samples <= '0;
    end else if (shift_en) begin
      samples <= NumSamples'({samples, bit_sel});
    end
  end

endmodule

// File: rtl/hyperbus_rwds_lat_sampler.sv
// RWDS latency sampler: counts tx_clk_90 edges after CS assertion, samples
// RWDS over a configurable window, majority-votes and reports per chip.
module hyperbus_rwds_lat_sampler
  import hyperbus_rwds_lat_sampler_pkg::*;
#(
  parameter int NumChips     = 2,
  parameter int EdgeIdxWidth = 4,
  parameter int NumSamples   = 3
) (
  input  logic                                              tx_clk_90,
  input  logic                                              rst_ni,
  input  logic [EdgeIdxWidth-1:0]                           cfg_edge_idx_i,
  input  logic                                              cfg_edge_pol_i,
  input  logic [NumChips-1:0]                               hyper_cs_ni,
  input  logic                                              hyper_rwds_i,
  output logic                                              rwds_sample_o,
  output logic                                              rwds_valid_o,
  output logic [((NumChips > 1) ? $clog2(NumChips) : 1)-1:0] rwds_chip_o,
  output logic [NumChips-1:0]                               rwds_lat_o,
  output logic                                              abort_o,
  output logic                                              cs_err_o
);

  localparam int ChipW    = (NumChips > 1) ? $clog2(NumChips) : 1;
  localparam int CntWidth = EdgeIdxWidth + 3;

  state_e                  state_q;
  logic [CntWidth-1:0]     cnt_q;
  logic [EdgeIdxWidth-1:0] idx_q;
  logic                    pol_q;
  logic [ChipW-1:0]        chip_q;

  logic                    cs_act;
  logic [NumChips-1:0]     cs_low;
  logic                    multi_low;
  logic [ChipW-1:0]        act_chip;
  logic [EdgeIdxWidth-1:0] idx_cur;
  logic                    pol_cur;
  logic [CntWidth-1:0]     win_lo;
  logic [CntWidth-1:0]     win_hi;
  logic                    sample_en;
  logic                    last_sample;
  logic                    cap_clear;
  logic [NumSamples-1:0]   samples;
  logic                    vote;

  assign cs_act    = ~&hyper_cs_ni;
  assign cs_low    = ~hyper_cs_ni;
  assign multi_low = |(cs_low & (cs_low - NumChips'(1)));

  always_comb begin
    act_chip = '0;
    for (int i = NumChips - 1; i >= 0; i--) begin
      if (!hyper_cs_ni[i]) act_chip = ChipW'(i);
    end
  end

  // The IDLE->COUNT edge is already a sampling edge for idx=0, so it has to
  // use the incoming configuration rather than the latched one.
  assign idx_cur = (state_q == IDLE) ? cfg_edge_idx_i : idx_q;
  assign pol_cur = (state_q == IDLE) ? cfg_edge_pol_i : pol_q;
  assign win_lo  = CntWidth'(idx_cur);
  assign win_hi  = win_lo + CntWidth'(NumSamples - 1);

  assign sample_en   = cs_act && ((state_q == IDLE) || (state_q == COUNT)) &&
                       (cnt_q >= win_lo) && (cnt_q <= win_hi);
  assign last_sample = sample_en && (cnt_q == win_hi);

  // Samples are emptied whenever a transaction ends so IDLE always starts clean.
  assign cap_clear = (state_q == VOTE) || ((state_q == COUNT) && !cs_act);

  hyperbus_rwds_dual_capture #(
    .NumSamples(NumSamples)
  ) u_capture (
    .tx_clk_90(tx_clk_90),
    .rst_ni   (rst_ni),
    .rwds     (hyper_rwds_i),
    .pol      (pol_cur),
    .shift_en (sample_en),
    .clear    (cap_clear),
    .samples  (samples)
  );

  assign vote = majority(7'(samples), NumSamples);

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      pol_q         <= 1'b0;
      chip_q        <= '0;
      rwds_sample_o <= 1'b0;
      rwds_valid_o  <= 1'b0;
      rwds_chip_o   <= '0;
      rwds_lat_o    <= '0;
      abort_o       <= 1'b0;
      cs_err_o      <= 1'b0;
    end else begin
      rwds_valid_o <= 1'b0;
      abort_o      <= 1'b0;
      if (multi_low) cs_err_o <= 1'b1;

      case (state_q)
        IDLE: begin
          if (cs_act) begin
            idx_q   <= cfg_edge_idx_i;
            pol_q   <= cfg_edge_pol_i;
            chip_q  <= act_chip;
            cnt_q   <= CntWidth'(1);
            state_q <= last_sample ? VOTE : COUNT;
          end
        end

        COUNT: begin
          if (!cs_act) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            abort_o <= 1'b1;
          end else begin
            if (cnt_q != {CntWidth{1'b1}}) cnt_q <= cnt_q + CntWidth'(1);
            if (last_sample) state_q <= VOTE;
          end
        end

        VOTE: begin
          rwds_sample_o      <= vote;
          rwds_valid_o       <= 1'b1;
          rwds_chip_o        <= chip_q;
          rwds_lat_o[chip_q] <= vote;
          cnt_q              <= '0;
          // One result per CS assertion: hold off until CS is seen released.
          state_q            <= cs_act ? WAIT_REL : IDLE;
        end

        WAIT_REL: begin
          if (!cs_act) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_rwds_lat_sampler.sv
// Directed bench for the RWDS latency sampler (NumChips=2, NumSamples=3).
module tb_hyperbus_rwds_lat_sampler;

  logic       tx_clk_90;
  logic       rst_ni;
  logic [3:0] cfg_edge_idx;
  logic       cfg_edge_pol;
  logic [1:0] hyper_cs_n;
  logic       hyper_rwds;
  logic       rwds_sample;
  logic       rwds_valid;
  logic [0:0] rwds_chip;
  logic [1:0] rwds_lat;
  logic       abort;
  logic       cs_err;

  int checks = 0;
  int errors = 0;

  hyperbus_rwds_lat_sampler #(
    .NumChips    (2),
    .EdgeIdxWidth(4),
    .NumSamples  (3)
  ) dut (
    .tx_clk_90     (tx_clk_90),
    .rst_ni        (rst_ni),
    .cfg_edge_idx_i(cfg_edge_idx),
    .cfg_edge_pol_i(cfg_edge_pol),
    .hyper_cs_ni   (hyper_cs_n),
    .hyper_rwds_i  (hyper_rwds),
    .rwds_sample_o (rwds_sample),
    .rwds_valid_o  (rwds_valid),
    .rwds_chip_o   (rwds_chip),
    .rwds_lat_o    (rwds_lat),
    .abort_o       (abort),
    .cs_err_o      (cs_err)
  );

  initial tx_clk_90 = 1'b0;
  always #5 tx_clk_90 = ~tx_clk_90;

  task automatic tick();
    @(posedge tx_clk_90);
    #1;
  endtask

  // Drives one CS assertion; pat[k-1] is RWDS for posedge k (edge 1 = IDLE->COUNT).
  task automatic drive_txn(input logic [3:0] idx, input logic pol, input logic [1:0] cs,
                           input logic [31:0] pat, input int ncyc,
                           output int vcycle, output int vcount, output int acount);
    cfg_edge_idx = idx;
    cfg_edge_pol = pol;
    hyper_cs_n   = cs;
    vcycle = -1;
    vcount = 0;
    acount = 0;
    for (int k = 1; k <= ncyc; k++) begin
      hyper_rwds = pat[k-1];
      tick();
      if (rwds_valid) begin
        vcount++;
        if (vcycle < 0) vcycle = k;
      end
      if (abort) acount++;
    end
  endtask

  task automatic release_cs();
    hyper_cs_n = 2'b11;
    hyper_rwds = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_ni       = 1'b0;
    cfg_edge_idx = 4'd0;
    cfg_edge_pol = 1'b0;
    hyper_cs_n   = 2'b11;
    hyper_rwds   = 1'b0;
    #2;
    checks++;
    if ({rwds_sample, rwds_valid, rwds_chip, rwds_lat, abort, cs_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000000",
               {rwds_sample, rwds_valid, rwds_chip, rwds_lat, abort, cs_err});
    end
    #10 rst_ni = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_latency();
    int vc, vn, an;
    drive_txn(4'd3, 1'b0, 2'b10, 32'hFFFF_FFFF, 20, vc, vn, an);
    checks++;
    if (vc !== 7) begin errors++; $display("FAIL latency_cycle got %0d want 7", vc); end
    checks++;
    if (vn !== 1) begin errors++; $display("FAIL latency_pulses got %0d want 1", vn); end
    checks++;
    if (an !== 0) begin errors++; $display("FAIL latency_abort got %0d want 0", an); end
    checks++;
    if ({rwds_sample, rwds_chip, rwds_lat} !== 4'b1_0_01) begin
      errors++;
      $display("FAIL latency_result got %b want 1001", {rwds_sample, rwds_chip, rwds_lat});
    end
    release_cs();
  endtask

  task automatic test_majority();
    int vc, vn, an;
    // Window edges 3,4,5 carry 1,0,1 on chip 1.
    drive_txn(4'd2, 1'b0, 2'b01, 32'h0000_0014, 10, vc, vn, an);
    checks++;
    if (vc !== 6) begin errors++; $display("FAIL maj101_cycle got %0d want 6", vc); end
    checks++;
    if ({rwds_sample, rwds_chip, rwds_lat} !== 4'b1_1_11) begin
      errors++;
      $display("FAIL maj101_result got %b want 1111", {rwds_sample, rwds_chip, rwds_lat});
    end
    release_cs();
    // Window edges 3,4,5 carry 0,1,0 on chip 0.
    drive_txn(4'd2, 1'b0, 2'b10, 32'h0000_0008, 10, vc, vn, an);
    checks++;
    if ({rwds_sample, rwds_chip, rwds_lat} !== 4'b0_0_10) begin
      errors++;
      $display("FAIL maj010_result got %b want 0010", {rwds_sample, rwds_chip, rwds_lat});
    end
    release_cs();
  endtask

  task automatic test_polarity();
    int vc, vn;
    for (int p = 0; p < 2; p++) begin
      cfg_edge_idx = 4'd2;
      cfg_edge_pol = p[0];
      hyper_cs_n   = 2'b10;
      hyper_rwds   = 1'b0;
      vc = -1;
      vn = 0;
      // RWDS pulses high around each negedge and is low at every posedge.
      for (int k = 1; k <= 10; k++) begin
        #2 hyper_rwds = 1'b1;
        #5 hyper_rwds = 1'b0;
        tick();
        if (rwds_valid) begin
          vn++;
          if (vc < 0) vc = k;
        end
      end
      checks++;
      if (vc !== 6) begin errors++; $display("FAIL pol%0d_cycle got %0d want 6", p, vc); end
      checks++;
      if (p == 0 && {rwds_sample, rwds_lat} !== 3'b0_10) begin
        errors++;
        $display("FAIL pol0_result got %b want 010", {rwds_sample, rwds_lat});
      end else if (p == 1 && {rwds_sample, rwds_lat} !== 3'b1_11) begin
        errors++;
        $display("FAIL pol1_result got %b want 111", {rwds_sample, rwds_lat});
      end
      release_cs();
    end
  endtask

  task automatic test_abort();
    int vc, vn, an;
    drive_txn(4'd10, 1'b0, 2'b01, 32'h0, 5, vc, vn, an);
    checks++;
    if (an !== 0) begin errors++; $display("FAIL abort_early got %0d want 0", an); end
    hyper_cs_n = 2'b11;
    tick();
    checks++;
    if ({abort, rwds_valid} !== 2'b10) begin
      errors++;
      $display("FAIL abort_pulse got %b want 10", {abort, rwds_valid});
    end
    tick();
    checks++;
    if ({abort, rwds_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_single got %b want 00", {abort, rwds_valid});
    end
    checks++;
    if ({rwds_sample, rwds_chip, rwds_lat} !== 4'b1_0_11) begin
      errors++;
      $display("FAIL abort_hold got %b want 1011", {rwds_sample, rwds_chip, rwds_lat});
    end
    release_cs();
  endtask

  task automatic test_idx_bounds();
    int vc, vn, an;
    drive_txn(4'd0, 1'b0, 2'b10, 32'h0000_0007, 6, vc, vn, an);
    checks++;
    if (vc !== 4) begin errors++; $display("FAIL idx0_cycle got %0d want 4", vc); end
    checks++;
    if ({rwds_sample, rwds_lat} !== 3'b1_11) begin
      errors++;
      $display("FAIL idx0_result got %b want 111", {rwds_sample, rwds_lat});
    end
    release_cs();
    // Only edges 16..18 are low; any window slip flips the vote.
    drive_txn(4'd15, 1'b0, 2'b10, 32'hFFFC_7FFF, 25, vc, vn, an);
    checks++;
    if (vc !== 19 || vn !== 1) begin
      errors++;
      $display("FAIL idx15_cycle got %0d/%0d want 19/1", vc, vn);
    end
    checks++;
    if ({rwds_sample, rwds_chip, rwds_lat} !== 4'b0_0_10) begin
      errors++;
      $display("FAIL idx15_result got %b want 0010", {rwds_sample, rwds_chip, rwds_lat});
    end
    release_cs();
  endtask

  task automatic test_multi_cs();
    int vc, vn, an;
    checks++;
    if (cs_err !== 1'b0) begin errors++; $display("FAIL cs_err_pre got %b want 0", cs_err); end
    drive_txn(4'd1, 1'b0, 2'b00, 32'hFFFF_FFFF, 8, vc, vn, an);
    checks++;
    if (vc !== 5) begin errors++; $display("FAIL multi_cycle got %0d want 5", vc); end
    checks++;
    if ({rwds_sample, rwds_chip, rwds_lat} !== 4'b1_0_11) begin
      errors++;
      $display("FAIL multi_result got %b want 1011", {rwds_sample, rwds_chip, rwds_lat});
    end
    release_cs();
    checks++;
    if (cs_err !== 1'b1) begin errors++; $display("FAIL cs_err_sticky got %b want 1", cs_err); end
  endtask

  task automatic test_reset_mid();
    int vc, vn, an, ab;
    drive_txn(4'd10, 1'b0, 2'b10, 32'hFFFF_FFFF, 4, vc, vn, an);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({rwds_sample, rwds_valid, rwds_chip, rwds_lat, abort, cs_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid got %b want 0000000",
               {rwds_sample, rwds_valid, rwds_chip, rwds_lat, abort, cs_err});
    end
    hyper_cs_n = 2'b11;
    #2 rst_ni = 1'b1;
    ab = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (abort) ab++;
    end
    checks++;
    if (ab !== 0) begin errors++; $display("FAIL reset_no_abort got %0d want 0", ab); end
    drive_txn(4'd3, 1'b0, 2'b10, 32'hFFFF_FFFF, 10, vc, vn, an);
    checks++;
    if (vc !== 7 || {rwds_sample, rwds_chip, rwds_lat} !== 4'b1_0_01) begin
      errors++;
      $display("FAIL reset_restart got %0d/%b want 7/1001", vc, {rwds_sample, rwds_chip, rwds_lat});
    end
    release_cs();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_majority();
    test_polarity();
    test_abort();
    test_idx_bounds();
    test_multi_cs();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
